// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit unit still needs a 1-bit counter to keep the datapath legal.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit adder slice; also exposes the carry into its MSB
// so the top can form the signed-overflow flag from the final slice.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] full;

    assign full     = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign s        = full[DIGIT-1:0];
    assign cout     = full[DIGIT];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign c_msb_in = s[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with valid/ready on both sides.
// state | meaning: IDLE accept operands | BUSY one digit per edge | DONE hold result
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    import addsub_pkg::*;

    localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam int CNT_W      = cnt_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_param_check
            $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [DIGIT-1:0]   a_dig, b_dig, s_dig;
    logic               cout_dig, c_msb_dig;

    // Constant-index mux keeps the digit select free of variable part-selects.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_dig = a_q[k*DIGIT +: DIGIT];
                b_dig = b_q[k*DIGIT +: DIGIT];
            end
        end
    end

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a        (a_dig),
        .b        (b_dig),
        .cin      (carry_q),
        .s        (s_dig),
        .cout     (cout_dig),
        .c_msb_in (c_msb_dig)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = x;
                    b_d     = y ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        sum_d[k*DIGIT +: DIGIT] = s_dig;
                    end
                end
                carry_d = cout_dig;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    c_out_d = cout_dig;
                    ovf_d   = cout_dig ^ c_msb_dig;
                    zero_d  = (sum_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three instances (DIGIT = 4, 1, 16) checked against
// an integer-arithmetic reference model with directed and random operations.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        sub = 1'b0;

    logic        iv[3];
    logic        orr[3];
    logic        ir[3];
    logic        ov[3];
    logic        co[3];
    logic        of[3];
    logic        zr[3];
    logic [15:0] sm[3];

    int lat[3] = '{4, 16, 1};
    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .x(x), .y(y), .sub(sub),
        .out_valid(ov[0]), .out_ready(orr[0]), .sum(sm[0]), .c_out(co[0]), .ovf(of[0]), .zero(zr[0])
    );

    addsub_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .x(x), .y(y), .sub(sub),
        .out_valid(ov[1]), .out_ready(orr[1]), .sum(sm[1]), .c_out(co[1]), .ovf(of[1]), .zero(zr[1])
    );

    addsub_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .x(x), .y(y), .sub(sub),
        .out_valid(ov[2]), .out_ready(orr[2]), .sum(sm[2]), .c_out(co[2]), .ovf(of[2]), .zero(zr[2])
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s (dut %0d): observed=%0h expected=%0h", tag, d, obs, exp);
    endtask

    // Signed/unsigned integer arithmetic, independent of any carry chain.
    task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input logic s,
                             output logic [15:0] r, output logic c, output logic v, output logic z);
        int    sa, sb, res;
        longint ua, ub;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        res = s ? (sa - sb) : (sa + sb);
        v   = (res > 32767) || (res < -32768);
        r   = res[15:0];
        ua  = longint'(a);
        ub  = longint'(b);
        c   = s ? (ua >= ub) : ((ua + ub) > 65535);
        z   = (r == 16'h0000);
    endtask

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b, input logic s,
                          input int hold, input bit noise);
        logic [15:0] er;
        logic        ec, ev, ez;
        int          edges;
        ref_model(a, b, s, er, ec, ev, ez);
        @(negedge clk);
        chk("idle_in_ready", d, 32'(ir[d]), 32'd1);
        x = a; y = b; sub = s; iv[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[d] = 1'b0;
        x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom);
        chk("busy_in_ready", d, 32'(ir[d]), 32'd0);
        chk("busy_out_valid", d, 32'(ov[d]), 32'd0);
        edges = 0;
        while (!ov[d] && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("latency", d, 32'(edges), 32'(lat[d]));
        chk("sum", d, 32'(sm[d]), 32'(er));
        chk("c_out", d, 32'(co[d]), 32'(ec));
        chk("ovf", d, 32'(of[d]), 32'(ev));
        chk("zero", d, 32'(zr[d]), 32'(ez));
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                iv[d] = 1'b1;
                x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            chk("hold_sum", d, 32'(sm[d]), 32'(er));
            chk("hold_out_valid", d, 32'(ov[d]), 32'd1);
            chk("hold_in_ready", d, 32'(ir[d]), 32'd0);
        end
        iv[d]  = 1'b0;
        orr[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        orr[d] = 1'b0;
        chk("release_out_valid", d, 32'(ov[d]), 32'd0);
        chk("release_in_ready", d, 32'(ir[d]), 32'd1);
        chk("idle_sum_held", d, 32'(sm[d]), 32'(er));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i]  = 1'b0;
            orr[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", i, 32'(ir[i]), 32'd0);
            chk("rst_out_valid", i, 32'(ov[i]), 32'd0);
            chk("rst_sum", i, 32'(sm[i]), 32'd0);
            chk("rst_flags", i, {29'd0, co[i], of[i], zr[i]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk("post_rst_in_ready", i, 32'(ir[i]), 32'd1);

        for (int d = 0; d < 3; d++) begin
            run_op(d, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
            run_op(d, 16'h0005, 16'h0007, 1'b1, 1, 1'b0);
            run_op(d, 16'h8000, 16'h0001, 1'b1, 0, 1'b0);
            run_op(d, 16'h1234, 16'h1234, 1'b1, 2, 1'b0);
            run_op(d, 16'h00FF, 16'h0F01, 1'b0, 10, 1'b1);
            run_op(d, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
            for (int n = 0; n < 12; n++) begin
                run_op(d, 16'($urandom), 16'($urandom), 1'($urandom),
                       int'($urandom_range(0, 3)), 1'($urandom));
            end
        end

        // Reset while the DIGIT=4 unit is about to process digit 2.
        @(negedge clk);
        x = 16'h1357; y = 16'h2468; sub = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 0, 32'(ov[0]), 32'd0);
        chk("midrst_sum", 0, 32'(sm[0]), 32'd0);
        chk("midrst_in_ready", 0, 32'(ir[0]), 32'd0);
        chk("midrst_flags", 0, {29'd0, co[0], of[0], zr[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", 0, 32'(ir[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_no_pulse", 0, 32'(ov[0]), 32'd0);
        end
        run_op(0, 16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor with a valid/ready handshake on both sides.
- Operands are latched on accept, then processed DIGIT bits per cycle, LSB first; the result is held until the consumer takes it.
- Sized as the shared arithmetic unit for small datapaths where area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 2).
- DIGIT, 4, bits processed per cycle. WIDTH % DIGIT must be 0; DIGIT = WIDTH gives a one-cycle unit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  unit can accept operands.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- sub  input  1  0 = x+y, 1 = x-y (computed as x + ~y + 1).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB. For sub, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset is asynchronous and active-high. Clock is clk, reset is rst; one clock domain.
- Reset values: state IDLE, digit counter 0, sum 0, c_out 0, ovf 0, zero 0, out_valid 0.
  - in_ready = (state==IDLE) & ~rst, so it is 0 while rst is high and 1 after release.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready at an edge: capture x, y^{WIDTH{sub}} and sub (as carry-in), clear the counter and sum register, go to BUSY.
  - Operands may change freely after accept.
- BUSY:
  - in_ready=0.
  - Each edge adds digit k of the stored operands with the running carry and writes it into sum[k*DIGIT +: DIGIT]. It then stores the digit carry-out and increments k.
  - On the edge processing the last digit (k = WIDTH/DIGIT-1), latch c_out, ovf and zero, then go to DONE.
  - ovf uses the carry into bit WIDTH-1 from the final slice.
- Latency: accept edge E0; out_valid is high after edge E(WIDTH/DIGIT). For DIGIT=WIDTH this is the next edge.
- DONE:
  - out_valid=1. sum and flags stay stable while out_ready=0, for any number of cycles.
  - On out_valid&out_ready, go to IDLE. out_valid=0 and in_ready=1 on the following cycle.
  - No same-cycle result-release/accept; throughput is one op per WIDTH/DIGIT+2 cycles.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Outputs hold their last values in IDLE; only out_valid qualifies them.
- rst asserted in any state (including mid-BUSY) immediately returns all registers to reset values. The partial result is discarded; there is no output pulse.

Decomposition:
- Package addsub_pkg:
  - state enum (IDLE, BUSY, DONE).
  - localparam function for NUM_DIGITS = WIDTH/DIGIT.
  - counter width = clog2(NUM_DIGITS), minimum 1.
- Sub-module addsub_digit:
  - combinational DIGIT-bit slice.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb_in (the carry into the slice MSB, for ovf).
- Top holds the FSM, operand registers, counter and result registers.
- Elaboration-time check fails if WIDTH % DIGIT != 0.

Test Plan:
- WIDTH=16, DIGIT=4, add 0x7FFF+0x0001:
  - sum=0x8000, ovf=1, c_out=0, zero=0.
  - out_valid rises exactly 4 edges after accept.
- Sub 0x0005-0x0007 -> sum=0xFFFE, c_out=0, ovf=0, zero=0.
- Sub 0x8000-0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
- Sub 0x1234-0x1234 -> sum=0x0000, zero=1, c_out=1, ovf=0.
- Backpressure, with 0x00FF+0x0F01 completed:
  - out_ready=0 for 10 cycles while in_valid=1 with new operands: sum=0x1000 stays stable, in_ready=0, new operands not taken.
  - out_ready=1 then returns to IDLE, and the next op is accepted.
- Reset and corner parameters:
  - rst pulse at BUSY digit 2: out_valid=0, sum=0, state IDLE immediately. A following 0x0001+0x0001 gives 0x0002.
  - Repeat the vectors above with DIGIT=1 (16-cycle latency) and DIGIT=16 (1-cycle latency); results must be identical.
